// File: rtl/bootrom_pkg.sv
// Shared types and helpers for the downloadable boot ROM.
package bootrom_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } dl_state_t;

    localparam int SUM_W = 16;

    function automatic int lanes(input int dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/bootrom_dl_packer.sv
// Packs download bytes little-endian into DW-bit words. word_o is the pack
// register with the incoming byte merged in; pack_o is the bare register.
module bootrom_dl_packer
    import bootrom_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clr_i,
    input  logic          byte_en_i,
    input  logic [7:0]    byte_i,
    output logic [1:0]    lane_o,
    output logic [DW-1:0] word_o,
    output logic [DW-1:0] pack_o,
    output logic          word_done_o
);

    localparam int         LANES = lanes(DW);
    localparam logic [1:0] LAST  = 2'(LANES - 1);

    logic [1:0]    lane_q;
    logic [DW-1:0] pack_q;

    always_comb begin
        word_o = pack_q;
        for (int l = 0; l < LANES; l++) begin
            if (lane_q == 2'(l)) begin
                word_o[l*8 +: 8] = byte_i;
            end
        end
    end

    assign word_done_o = byte_en_i && (lane_q == LAST);
    assign lane_o      = lane_q;
    assign pack_o      = pack_q;

    // Clearing on word completion keeps unfilled lanes zero for a partial flush.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            lane_q <= 2'd0;
            pack_q <= '0;
        end else if (byte_en_i) begin
            if (word_done_o) begin
                lane_q <= 2'd0;
                pack_q <= '0;
            end else begin
                lane_q <= lane_q + 2'd1;
                pack_q <= word_o;
            end
        end
    end

endmodule

// File: rtl/bootrom_dl.sv
// Boot ROM loaded at runtime from a byte stream, with registered CPU reads.
// Optional byte checksum output enabled by defining BOOTROM_DL_CKSUM_EN.
module bootrom_dl
    import bootrom_pkg::*;
#(
    parameter int          AW        = 12,
    parameter int          DW        = 8,
    parameter logic [15:0] BASE      = 16'h0000,
    parameter              INIT_FILE = ""
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic [15:0]   A,
    input  logic          RD,
    output logic [DW-1:0] DB_O,
    output logic          DB_OE,
    output logic          nCS,
    input  logic          DL_EN,
    input  logic          DL_VALID,
    input  logic [7:0]    DL_DATA,
    output logic          DL_READY,
    output logic          DL_DONE,
    output logic          DL_OVF
`ifdef BOOTROM_DL_CKSUM_EN
    ,
    output logic [SUM_W-1:0] DL_SUM
`endif
);

    dl_state_t     state_q;
    logic [AW:0]   addr_q;
    logic          ready_q;
    logic          done_q;
    logic          ovf_q;
    logic [DW-1:0] db_q;
    logic          db_oe_q;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    logic          load_start;
    logic          accept;
    logic          keep;
    logic          drop;
    logic          rd_hit;
    logic          flush_wr;
    logic          we;
    logic [DW-1:0] wdata;
    logic [1:0]    lane;
    logic [DW-1:0] word_full;
    logic [DW-1:0] word_part;
    logic          word_done;

    assign nCS = (A[15:AW] != BASE[15-AW:0]);

    // READY drops in the same cycle DL_EN falls so that cycle's byte is refused.
    assign DL_READY   = ready_q && DL_EN;
    assign load_start = (state_q == IDLE) && DL_EN;
    assign accept     = (state_q == LOAD) && DL_READY && DL_VALID;
    assign keep       = accept && !addr_q[AW];
    assign drop       = accept && addr_q[AW];
    assign rd_hit     = RD && !nCS && (state_q == IDLE);
    assign flush_wr   = (state_q == FLUSH) && (lane != 2'd0) && !addr_q[AW];
    assign we         = (keep && word_done) || flush_wr;
    assign wdata      = flush_wr ? word_part : word_full;

    bootrom_dl_packer #(
        .DW (DW)
    ) u_packer (
        .clk_i       (CLK),
        .rst_i       (RESET),
        .clr_i       (load_start),
        .byte_en_i   (keep),
        .byte_i      (DL_DATA),
        .lane_o      (lane),
        .word_o      (word_full),
        .pack_o      (word_part),
        .word_done_o (word_done)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            addr_q  <= '0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (DL_EN) begin
                        state_q <= LOAD;
                        addr_q  <= '0;
                        ovf_q   <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                LOAD: begin
                    if (keep && word_done) begin
                        addr_q <= addr_q + 1'b1;
                    end
                    if (drop) begin
                        ovf_q <= 1'b1;
                    end
                    if (!DL_EN) begin
                        state_q <= FLUSH;
                        ready_q <= 1'b0;
                    end
                end
                FLUSH: begin
                    state_q <= DONE;
                    done_q  <= 1'b1;
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // Memory has no reset so its contents survive a reset mid-download.
    always_ff @(posedge CLK) begin
        if (we) begin
            mem[addr_q[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            db_q    <= '0;
            db_oe_q <= 1'b0;
        end else begin
            db_oe_q <= rd_hit;
            if (rd_hit) begin
                db_q <= mem[A[AW-1:0]];
            end
        end
    end

    assign DB_O    = db_q;
    assign DB_OE   = db_oe_q;
    assign DL_DONE = done_q;
    assign DL_OVF  = ovf_q;

`ifdef BOOTROM_DL_CKSUM_EN
    logic [SUM_W-1:0] sum_q;

    // Dropped overflow bytes still count towards the sum.
    always_ff @(posedge CLK) begin
        if (RESET || load_start) begin
            sum_q <= '0;
        end else if (accept) begin
            sum_q <= sum_q + {{(SUM_W-8){1'b0}}, DL_DATA};
        end
    end

    assign DL_SUM = sum_q;
`endif

endmodule

// File: tb/tb_bootrom_dl.sv
// Randomized scoreboard bench for bootrom_dl (AW=4, DW=16, BASE=0xABC).
module tb_bootrom_dl;

    localparam int          AW    = 4;
    localparam int          DW    = 16;
    localparam int          DEPTH = 16;
    localparam int          CAP   = DEPTH * 2;
    localparam logic [15:0] BASE  = 16'h0ABC;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [15:0] A = '0;
    logic        RD = 1'b0;
    logic [15:0] DB_O;
    logic        DB_OE;
    logic        nCS;
    logic        DL_EN = 1'b0;
    logic        DL_VALID = 1'b0;
    logic [7:0]  DL_DATA = '0;
    logic        DL_READY;
    logic        DL_DONE;
    logic        DL_OVF;
`ifdef BOOTROM_DL_CKSUM_EN
    logic [15:0] DL_SUM;
`endif

    bootrom_dl #(
        .AW   (AW),
        .DW   (DW),
        .BASE (BASE)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .A        (A),
        .RD       (RD),
        .DB_O     (DB_O),
        .DB_OE    (DB_OE),
        .nCS      (nCS),
        .DL_EN    (DL_EN),
        .DL_VALID (DL_VALID),
        .DL_DATA  (DL_DATA),
        .DL_READY (DL_READY),
        .DL_DONE  (DL_DONE),
        .DL_OVF   (DL_OVF)
`ifdef BOOTROM_DL_CKSUM_EN
        ,
        .DL_SUM   (DL_SUM)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int          cyc;
        logic [15:0] data;
    } rd_exp_t;

    typedef struct {
        int          cyc;
        logic        ovf;
        logic [15:0] sum;
    } done_exp_t;

    rd_exp_t     rq[$];
    done_exp_t   dq[$];
    logic [15:0] ref_mem [DEPTH];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic        exp_oe;
    logic        exp_done;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", name, cyc, got, exp);
        end
    endtask

    // Monitor: compare DUT outputs against queued expectations.
    always begin
        @(posedge CLK);
        cyc++;
        #1;
        if (!RESET) begin
            exp_oe = (rq.size() > 0) && (rq[0].cyc == cyc);
            if (DB_OE || exp_oe) begin
                checks++;
                if (DB_OE !== exp_oe) begin
                    failures++;
                    $display("FAIL db_oe cyc=%0d got=%b exp=%b", cyc, DB_OE, exp_oe);
                end else if (DB_O !== rq[0].data) begin
                    failures++;
                    $display("FAIL db_o cyc=%0d got=0x%0h exp=0x%0h", cyc, DB_O, rq[0].data);
                end
                if (exp_oe) void'(rq.pop_front());
            end
            exp_done = (dq.size() > 0) && (dq[0].cyc == cyc);
            if (DL_DONE || exp_done) begin
                checks++;
                if (DL_DONE !== exp_done) begin
                    failures++;
                    $display("FAIL dl_done cyc=%0d got=%b exp=%b", cyc, DL_DONE, exp_done);
                end else begin
                    check("dl_ovf", 32'(DL_OVF), 32'(dq[0].ovf));
`ifdef BOOTROM_DL_CKSUM_EN
                    check("dl_sum", 32'(DL_SUM), 32'(dq[0].sum));
`endif
                end
                if (exp_done) void'(dq.pop_front());
            end
        end
    end

    // Reference: byte stream -> little-endian 16-bit words, capacity CAP bytes.
    task automatic apply_bytes(input logic [7:0] b[$], input bit complete_only);
        int lim;
        lim = complete_only ? (b.size() / 2) * 2 : b.size();
        if (lim > CAP) lim = CAP;
        for (int i = 0; i < lim; i += 2) begin
            ref_mem[i/2] = {(i + 1 < lim) ? b[i+1] : 8'h00, b[i]};
        end
    endtask

    task automatic do_read(input logic [15:0] addr);
        @(negedge CLK);
        A  = addr;
        RD = 1'b1;
        #1;
        check("ncs", 32'(nCS), 32'(addr[15:4] != BASE[11:0]));
        if (addr[15:4] == BASE[11:0]) rq.push_back('{cyc + 1, ref_mem[addr[3:0]]});
    endtask

    task automatic read_burst(input int n);
        logic [15:0] ad;
        for (int i = 0; i < n; i++) begin
            ad = ($urandom_range(0, 4) == 0) ? 16'($urandom) : {BASE[11:0], 4'($urandom)};
            do_read(ad);
        end
        @(negedge CLK);
        RD = 1'b0;
    endtask

    // fixed < 0 selects random bytes; rd_noise issues reads that must be ignored.
    task automatic download(input int n, input int fixed, input bit rd_noise);
        logic [7:0]  b[$];
        logic [15:0] s;
        s = '0;
        @(negedge CLK);
        RD    = 1'b0;
        DL_EN = 1'b1;
        @(negedge CLK);
        while (b.size() < n) begin
            DL_VALID = ($urandom_range(0, 3) != 0);
            DL_DATA  = (fixed >= 0) ? fixed[7:0] : 8'($urandom);
            RD       = rd_noise && ($urandom_range(0, 2) == 0);
            A        = {BASE[11:0], 4'($urandom)};
            #1;
            check("ready_load", 32'(DL_READY), 32'd1);
            if (DL_VALID) begin
                b.push_back(DL_DATA);
                s = s + 16'(DL_DATA);
            end
            @(negedge CLK);
        end
        DL_EN    = 1'b0;
        DL_VALID = 1'b1;
        DL_DATA  = 8'($urandom);
        RD       = 1'b0;
        #1;
        check("ready_fall", 32'(DL_READY), 32'd0);
        dq.push_back('{cyc + 2, (n > CAP), s});
        apply_bytes(b, 1'b0);
        @(negedge CLK);
        DL_VALID = 1'b0;
        repeat (3) @(negedge CLK);
    endtask

    task automatic reset_mid_download(input int nb);
        logic [7:0] b[$];
        @(negedge CLK);
        DL_EN = 1'b1;
        @(negedge CLK);
        for (int i = 0; i < nb; i++) begin
            DL_VALID = 1'b1;
            DL_DATA  = 8'($urandom);
            b.push_back(DL_DATA);
            @(negedge CLK);
        end
        RESET    = 1'b1;
        DL_EN    = 1'b0;
        DL_VALID = 1'b0;
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        check("rst_ready", 32'(DL_READY), 32'd0);
        check("rst_ovf", 32'(DL_OVF), 32'd0);
        check("rst_oe", 32'(DB_OE), 32'd0);
`ifdef BOOTROM_DL_CKSUM_EN
        check("rst_sum", 32'(DL_SUM), 32'd0);
`endif
        apply_bytes(b, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge CLK);
        check("rst_db_o", 32'(DB_O), 32'd0);
        check("rst_db_oe", 32'(DB_OE), 32'd0);
        check("rst_dl_ready", 32'(DL_READY), 32'd0);
        check("rst_dl_done", 32'(DL_DONE), 32'd0);
        check("rst_dl_ovf", 32'(DL_OVF), 32'd0);
        RESET = 1'b0;

        download(CAP, -1, 1'b0);
        for (int i = 0; i < DEPTH; i++) do_read({BASE[11:0], 4'(i)});
        do_read(16'h1000);
        do_read(16'h0000);
        @(negedge CLK);
        RD = 1'b0;

        download(3, -1, 1'b1);
        read_burst(12);
        download(CAP + 1, -1, 1'b0);
        read_burst(12);
        for (int k = 0; k < 8; k++) begin
            download($urandom_range(1, CAP + 8), -1, 1'b1);
            read_burst(10);
        end

        reset_mid_download(3);
        do_read({BASE[11:0], 4'h0});
        do_read({BASE[11:0], 4'h1});
        @(negedge CLK);
        RD = 1'b0;

`ifdef BOOTROM_DL_CKSUM_EN
        download(300, 255, 1'b0);
        check("sum_ff_x300", 32'(DL_SUM), 32'h2AD4);
        read_burst(4);
`endif

        repeat (5) @(negedge CLK);
        check("rd_queue_drained", 32'(rq.size()), 32'd0);
        check("done_queue_drained", 32'(dq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
